// File: rtl/if_pc_gen.sv
// if_pc_gen: PC generator with one-outstanding fetch and IF/ID register; instruction shows 1 cycle after rvalid.
// stall_i[0] gates new requests, stall_i[1] holds IF/ID (response parks in skid); IF_PC_GEN_DROP_CNT_EN adds drop counter.
module if_pc_gen #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [5:0]            stall_i,
  input  logic                  flush_jump_i,
  input  logic                  flush_int_i,
  input  logic [ADDR_WIDTH-1:0] new_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_valid_o,
  output logic [15:0]           drop_cnt_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_SKID = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]           skid_dat_q, skid_dat_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]           inst_q, inst_d;
  logic                  inst_vld_q, inst_vld_d;
  logic                  drop_q, drop_d;

  logic redirect;
  logic req;
  logic gnt;
  logic rsp;
  logic unused_stall;

  assign redirect     = flush_jump_i | flush_int_i;
  // Gating with rst_n_i keeps the request low while reset is held yet live on the first cycle after release.
  assign req          = rst_n_i & (state_q == S_REQ) & ~stall_i[0];
  assign gnt          = req & imem_gnt_i;
  assign rsp          = (state_q == S_WAIT) & imem_rvalid_i;
  assign unused_stall = ^stall_i[5:2];

  assign imem_req_o   = req;
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_vld_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    skid_pc_d  = skid_pc_q;
    skid_dat_d = skid_dat_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_vld_d = inst_vld_q;
    drop_d     = drop_q;

    if (!stall_i[1]) begin
      inst_vld_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_WIDTH'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall_i[1]) begin
            inst_d     = imem_rdata_i;
            inst_pc_d  = req_pc_q;
            inst_vld_d = 1'b1;
            state_d    = S_REQ;
          end else begin
            skid_dat_d = imem_rdata_i;
            skid_pc_d  = req_pc_q;
            state_d    = S_SKID;
          end
        end
      end
      S_SKID: begin
        if (!stall_i[1]) begin
          inst_d     = skid_dat_q;
          inst_pc_d  = skid_pc_q;
          inst_vld_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins over stalls; an owed response is tracked through the drop flag.
    if (redirect) begin
      pc_d       = new_pc_i;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      inst_vld_d = 1'b0;
      if ((state_q == S_REQ && gnt) || (state_q == S_WAIT && !imem_rvalid_i)) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      skid_pc_q  <= '0;
      skid_dat_q <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      skid_pc_q  <= skid_pc_d;
      skid_dat_q <= skid_dat_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_vld_q <= inst_vld_d;
      drop_q     <= drop_d;
    end
  end

`ifdef IF_PC_GEN_DROP_CNT_EN
  logic        discard;
  logic [15:0] drop_cnt_q;

  assign discard = rsp & (drop_q | redirect);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt_q <= '0;
    end else if (discard && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC/address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_i  in  6  stall vector from pipeline control; bit0 stalls PC/fetch issue, bit1 holds IF/ID output.
REQ-006 SHALL have port flush_jump_i  in  1  jump/branch redirect.
REQ-007 SHALL have port flush_int_i  in  1  interrupt redirect.
REQ-008 SHALL have port new_pc_i  in  ADDR_WIDTH  redirect target, already prioritised upstream.
REQ-009 SHALL have ports imem_req_o (out, 1), imem_addr_o (out, ADDR_WIDTH), imem_gnt_i (in, 1), imem_rvalid_i (in, 1), imem_rdata_i (in, 32): one-outstanding instruction bus.
REQ-010 SHALL have ports inst_o (out, 32), inst_pc_o (out, ADDR_WIDTH), inst_valid_o (out, 1): IF/ID register toward decode.
REQ-011 SHALL have port drop_cnt_o  out  16  discarded-response count (see Configuration).

Function
REQ-012 SHALL define redirect = flush_jump_i | flush_int_i; redirect overrides every stall.
REQ-013 SHALL implement states S_REQ (request asserted), S_WAIT (granted, awaiting rvalid), S_SKID (response buffered while bit1 stalled).
REQ-014 SHALL drive imem_req_o=1 only in S_REQ with stall_i[0]=0, imem_addr_o=pc.
REQ-015 SHALL go S_REQ->S_WAIT on imem_gnt_i & imem_req_o, latching req_pc=pc and pc<=pc+4 (modulo 2^ADDR_WIDTH, wrap without flag).
REQ-016 SHALL, in S_WAIT on rvalid with no drop pending and stall_i[1]=0, load inst_o=rdata, inst_pc_o=req_pc, inst_valid_o=1, go S_REQ; fetch-to-output latency = 1 cycle after rvalid.
REQ-017 SHALL, in S_WAIT on rvalid with stall_i[1]=1, capture rdata/req_pc into skid, go S_SKID; outputs held.
REQ-018 SHALL, in S_SKID when stall_i[1]=0, move skid to outputs with inst_valid_o=1, go S_REQ; no new request issued while in S_SKID.
REQ-019 SHALL, when stall_i[1]=0 and no instruction is loaded that cycle, clear inst_valid_o (bubble); stall_i[1]=1 holds all three outputs unchanged.
REQ-020 SHALL on redirect: pc<=new_pc_i, inst_valid_o<=0, skid discarded, next state S_REQ unless a granted response is still owed.
REQ-021 SHALL on redirect in S_REQ with gnt same cycle: set drop flag, go S_WAIT; without gnt, retarget imem_addr_o to new_pc_i next cycle (bus permits retargeting ungranted requests).
REQ-022 SHALL on redirect in S_WAIT without rvalid: set drop flag, stay S_WAIT; with rvalid same cycle: discard that response, go S_REQ.
REQ-023 SHALL discard the response arriving with drop flag set, clear the flag, go S_REQ; at most one response outstanding at any time.
REQ-024 SHALL ignore imem_rvalid_i outside S_WAIT.

Reset
REQ-025 SHALL asynchronously on rst_n_i=0 set pc=RESET_PC, state S_REQ, drop flag 0, skid empty, imem_req_o=0, inst_o=0, inst_pc_o=0, inst_valid_o=0, drop_cnt_o=0.
REQ-026 SHALL assert first imem_req_o in the first cycle after rst_n_i deasserts; reset mid-transaction abandons the outstanding response.

Configuration
REQ-027 SHALL, with IF_PC_GEN_DROP_CNT_EN defined, increment drop_cnt_o by 1 per discarded response (REQ-022/REQ-023), saturating at 16'hFFFF.
REQ-028 SHALL, without IF_PC_GEN_DROP_CNT_EN, tie drop_cnt_o to 0 and synthesise no counter.

Verification
REQ-029 SHALL test reset release, gnt same cycle, rvalid next cycle -> addrs 0x0,0x4,0x8 issued; inst_pc_o 0x0,0x4 with inst_valid_o=1.
REQ-030 SHALL test stall_i=6'b000111 during S_WAIT, rvalid arrives -> S_SKID, outputs frozen; stall released -> skid instruction appears next cycle, no request issued meanwhile.
REQ-031 SHALL test flush_jump_i, new_pc_i=0x100 in S_WAIT -> late rvalid discarded, next request addr 0x100, inst_valid_o=0, drop_cnt_o=1 (macro on).
REQ-032 SHALL test flush_int_i with rvalid same cycle -> response discarded, next addr = new_pc_i, drop flag not left set.
REQ-033 SHALL test pc=2^ADDR_WIDTH-4 fetch -> next addr 0x0; rst_n_i low mid S_WAIT -> all outputs zero immediately, restart at RESET_PC.
